// File: rtl/msg_scroll_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | msg_scroll_buffer_if : control/status bundle for the message scroller.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface msg_scroll_buffer_if #(
   parameter int DEPTH  = 16,
   parameter int DIGITS = 8
);
   logic                    en;
   logic                    dir;
   logic                    wr_en;
   logic [3:0]              wr_char;
   logic                    clear;
   logic [DIGITS*4-1:0]     window;
   logic [$clog2(DEPTH):0]  len;
   logic                    full;
   logic                    tick;

   modport master (
      output en, dir, wr_en, wr_char, clear,
      input  window, len, full, tick
   );

   modport slave (
      input  en, dir, wr_en, wr_char, clear,
      output window, len, full, tick
   );
endinterface
`default_nettype wire

// File: rtl/msg_scroll_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | msg_scroll_buffer : loadable 4-bit character message, scrolled through   |
// | a registered DIGITS-wide window at a prescaled tick rate.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module msg_scroll_buffer #(
   parameter int         DEPTH    = 16,
   parameter int         DIGITS   = 8,
   parameter int         TICK_DIV = 50_000_000,
   parameter logic [3:0] BLANK    = 4'd4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   msg_scroll_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [LW-1:0] DIGITS_L = LW'(DIGITS);
   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(TICK_DIV - 1);

   logic [3:0]          mem [DEPTH];
   logic [LW-1:0]       len_q;
   logic [AW-1:0]       head;
   logic [CW-1:0]       count;
   logic                tick_q;
   logic [DIGITS*4-1:0] window_q;

   logic [LW-1:0]       eff_len;
   logic [LW-1:0]       head_inc;
   logic [LW-1:0]       idx;
   logic [AW-1:0]       step_left;
   logic [AW-1:0]       step_right;
   logic [DIGITS*4-1:0] window_next;
   logic                full;
   logic                accept;

   assign full   = (len_q == DEPTH_L);
   assign accept = bus.wr_en && !full;

   always_comb begin
      eff_len     = (len_q > DIGITS_L) ? len_q : DIGITS_L;
      head_inc    = {1'b0, head} + LW'(1);
      step_left   = (head_inc == eff_len) ? '0 : head_inc[AW-1:0];
      step_right  = (head == '0) ? AW'(eff_len - LW'(1)) : head - AW'(1);
      idx         = '0;
      window_next = '0;
      // head < EL and k < EL, so one conditional subtract performs the modulo
      for (int k = 0; k < DIGITS; k++) begin
         idx = {1'b0, head} + LW'(k);
         if (idx >= eff_len)
            idx = idx - eff_len;
         window_next[4*k +: 4] = (idx < len_q) ? mem[idx[AW-1:0]] : BLANK;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= BLANK;
         len_q    <= '0;
         head     <= '0;
         count    <= '0;
         tick_q   <= 1'b0;
         window_q <= {DIGITS{BLANK}};
      end else begin
         window_q <= window_next;
         if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++)
               mem[i] <= BLANK;
            len_q  <= '0;
            head   <= '0;
            count  <= '0;
            tick_q <= 1'b0;
         end else begin
            if (accept) begin
               mem[len_q[AW-1:0]] <= bus.wr_char;
               len_q              <= len_q + LW'(1);
            end
            if (tick_q)
               head <= bus.dir ? step_right : step_left;
            if (bus.en) begin
               tick_q <= (count == LAST_CNT);
               count  <= (count == LAST_CNT) ? '0 : count + CW'(1);
            end else begin
               tick_q <= 1'b0;
            end
         end
      end
   end

   assign bus.window = window_q;
   assign bus.len    = len_q;
   assign bus.full   = full;
   assign bus.tick   = tick_q;
endmodule
`default_nettype wire

// File: tb/tb_msg_scroll_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_msg_scroll_buffer : directed + random bench with a queue-level model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_msg_scroll_buffer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   msg_scroll_buffer_if #(.DEPTH(16), .DIGITS(8)) bus ();

   msg_scroll_buffer #(
      .DEPTH(16), .DIGITS(8), .TICK_DIV(4), .BLANK(4'd4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Model state: message contents, scroll offset, prescaler phase.
   int          m_buf [16];
   int          m_len;
   int          m_head;
   int          m_cnt;
   bit          m_tick;
   logic [31:0] m_win;
   int          codes [16];
   logic [31:0] start_win;

   function automatic logic [31:0] view();
      int          el = (m_len > 8) ? m_len : 8;
      logic [31:0] w  = '0;
      for (int k = 0; k < 8; k++) begin
         int i = (m_head + k) % el;
         w[4*k +: 4] = (i < m_len) ? 4'(m_buf[i]) : 4'd4;
      end
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_buf[i] = 4;
      m_len  = 0;
      m_head = 0;
      m_cnt  = 0;
      m_tick = 1'b0;
      m_win  = 32'h44444444;
   endtask

   task automatic model_edge();
      logic [31:0] nw = view();
      int          el = (m_len > 8) ? m_len : 8;
      if (bus.clear) begin
         for (int i = 0; i < 16; i++) m_buf[i] = 4;
         m_len  = 0;
         m_head = 0;
         m_cnt  = 0;
         m_tick = 1'b0;
      end else begin
         if (bus.wr_en && m_len < 16) begin
            m_buf[m_len] = int'(bus.wr_char);
            m_len++;
         end
         if (m_tick)
            m_head = bus.dir ? (m_head + el - 1) % el : (m_head + 1) % el;
         if (bus.en) begin
            m_tick = (m_cnt == 3);
            m_cnt  = (m_cnt + 1) % 4;
         end else begin
            m_tick = 1'b0;
         end
      end
      m_win = nw;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("window", bus.window, m_win);
      chk("len", 32'(bus.len), 32'(m_len));
      chk("full", 32'(bus.full), 32'(m_len == 16));
      chk("tick", 32'(bus.tick), 32'(m_tick));
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else       model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int guard;
      bus.en      = 1'b0;
      bus.dir     = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_char = 4'd0;
      bus.clear   = 1'b0;
      model_reset();

      step();
      reset = 1'b0;
      step();
      chk("rst_window", bus.window, 32'h44444444);
      chk("rst_len", 32'(bus.len), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_tick", 32'(bus.tick), 32'd0);

      // Build up state, then assert reset between edges.
      bus.en      = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_char = 4'd2;
      step();
      bus.wr_en = 1'b0;
      repeat (2) step();
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("async_window", bus.window, 32'h44444444);
      chk("async_len", 32'(bus.len), 32'd0);
      chk("async_tick", 32'(bus.tick), 32'd0);
      check_all();
      step();
      reset  = 1'b0;
      bus.en = 1'b0;

      // HELLO with the prescaler stopped.
      codes[0] = 0; codes[1] = 1; codes[2] = 2; codes[3] = 2; codes[4] = 3;
      for (int i = 0; i < 5; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_char = 4'(codes[i]);
         step();
      end
      bus.wr_en = 1'b0;
      step();
      chk("hello_window", bus.window, 32'h44432210);
      chk("hello_len", 32'(bus.len), 32'd5);
      chk("hello_tick", 32'(bus.tick), 32'd0);

      bus.en  = 1'b1;
      bus.dir = 1'b0;
      repeat (6) step();
      chk("left_1", bus.window, 32'h04443221);
      repeat (28) step();
      chk("left_8", bus.window, 32'h44432210);
      bus.dir = 1'b1;
      repeat (4) step();
      chk("right_1", bus.window, 32'h44322104);
      bus.en = 1'b0;

      // Fill to DEPTH, then one refused write.
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      for (int i = 0; i < 16; i++) begin
         codes[i]    = int'($urandom_range(0, 4));
         bus.wr_en   = 1'b1;
         bus.wr_char = 4'(codes[i]);
         step();
      end
      bus.wr_char = 4'd3;
      step();
      bus.wr_en = 1'b0;
      start_win = '0;
      for (int k = 0; k < 8; k++) start_win[4*k +: 4] = 4'(codes[k]);
      chk("full_flag", 32'(bus.full), 32'd1);
      chk("full_len", 32'(bus.len), 32'd16);
      chk("full_window", bus.window, start_win);

      bus.en  = 1'b1;
      bus.dir = 1'b0;
      repeat (66) step();
      chk("wrap_16", bus.window, start_win);

      guard = 0;
      while (!(m_head == 3 && m_tick) && guard < 64) begin
         step();
         guard++;
      end
      chk("find_head3", 32'(guard < 64), 32'd1);
      chk("tick_at_clear", 32'(bus.tick), 32'd1);

      bus.clear   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_char = 4'd1;
      step();
      bus.clear = 1'b0;
      bus.wr_en = 1'b0;
      chk("clear_len", 32'(bus.len), 32'd0);
      for (int n = 1; n <= 4; n++) begin
         step();
         if (n == 1) chk("clear_window", bus.window, 32'h44444444);
         chk("clear_tick_phase", 32'(bus.tick), 32'(n == 4));
      end

      repeat (400) begin
         bus.en      = ($urandom_range(0, 3) != 0);
         bus.dir     = 1'($urandom_range(0, 1));
         bus.wr_en   = ($urandom_range(0, 2) == 0);
         bus.wr_char = 4'($urandom_range(0, 4));
         bus.clear   = ($urandom_range(0, 59) == 0);
         step();
      end

      bus.en    = 1'b0;
      bus.wr_en = 1'b0;
      bus.clear = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
